// File: rtl/spike_demux_pkg.sv
// Shared sizing, types and state encoding for the two-network spike output demux.
package spike_demux_pkg;

    localparam int DEMUX_Q        = 2;
    localparam int DEMUX_HALF_LEN = 18;
    localparam int TIME_W         = $clog2(DEMUX_HALF_LEN);

    function automatic int slot_w(input int half_len);
        return $clog2(2 * half_len);
    endfunction

    // Half-relative first-spike time; "time" is a keyword, hence slot_time.
    typedef struct packed {
        logic              valid;
        logic [TIME_W-1:0] slot_time;
    } spike_time_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE_ONLY,
        RUN
    } demux_state_t;

endpackage

// File: rtl/spike_output_demux_if.sv
// Column-side and macrocolumn-side signals of the spike output demux.
interface spike_output_demux_if #(
    parameter int Q = 2
);
    logic         gamma_start;
    logic [Q-1:0] col_spikes;
    logic [Q-1:0] output_spikes1;
    logic [Q-1:0] output_spikes2;
    logic         replay_valid;
    logic         early_start;

    modport master (
        output gamma_start, col_spikes,
        input  output_spikes1, output_spikes2, replay_valid, early_start
    );

    modport slave (
        input  gamma_start, col_spikes,
        output output_spikes1, output_spikes2, replay_valid, early_start
    );
endinterface

// File: rtl/spike_capture_bank.sv
// Q-entry first-spike-time capture for one network half, cleared on window swap.
module spike_capture_bank
    import spike_demux_pkg::*;
#(
    parameter int Q = DEMUX_Q
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic [Q-1:0]        spikes_i,
    input  logic [TIME_W-1:0]   time_i,
    output spike_time_t [Q-1:0] bank_o
);

    spike_time_t [Q-1:0] bank_q, bank_d;

    always_comb begin
        for (int q = 0; q < Q; q++) begin
            // NOTE: bank_d is given a value before any condition, so no latch can be inferred.
            bank_d[q] = clear_i ? '0 : bank_q[q];
            // A spike coincident with the clear lands in the fresh window.
            if (en_i && spikes_i[q] && !bank_d[q].valid) begin
                bank_d[q].valid     = 1'b1;
                bank_d[q].slot_time = time_i;
            end
        end
    end

    // NOTE: these few entries are flops, not RAM, so reset clears them and a restart can never replay stale times.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bank_q <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
            bank_q <= bank_d;
        end
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/spike_output_demux.sv
// Captures two networks' first spikes from one shared double window and replays them aligned next window.
// Optional SPIKE_DEMUX_HOLD_EN: replayed outputs hold high until the cycle after the next gamma_start.
module spike_output_demux
    import spike_demux_pkg::*;
#(
    parameter int Q        = DEMUX_Q,
    parameter int HALF_LEN = DEMUX_HALF_LEN
) (
    input  logic                 clk,
    input  logic                 rstb,
    spike_output_demux_if.slave  io
);

    localparam int                SLOT_W    = slot_w(HALF_LEN);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * HALF_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(HALF_LEN);

    demux_state_t        state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d, slot;
    spike_time_t [Q-1:0] cap1, cap2, rep1_q, rep1_d, rep2_q, rep2_d;
    logic [Q-1:0]        out1_q, out1_d, out2_q, out2_d, hit1, hit2;
    logic                replay_valid_q, early_start_q, early_start_d;
    logic                capture_on, replay_on, in_half1;
    logic [TIME_W-1:0]   time1, time2;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (io.gamma_start) state_d = CAPTURE_ONLY;
            CAPTURE_ONLY: if (io.gamma_start) state_d = RUN;
            RUN:          state_d = RUN;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        slot       = io.gamma_start ? '0 : slot_q;
        slot_d     = (slot == SLOT_LAST) ? slot : slot + SLOT_W'(1);
        in_half1   = slot < SLOT_HALF;
        capture_on = state_d != IDLE;
        // Replay keys off the next state so the window opened by a gamma_start replays from its slot 0.
        replay_on  = state_d == RUN;
        time1      = TIME_W'(slot);
        time2      = TIME_W'(slot - SLOT_HALF);
        rep1_d     = io.gamma_start ? cap1 : rep1_q;
        rep2_d     = io.gamma_start ? cap2 : rep2_q;
        for (int q = 0; q < Q; q++) begin
            hit1[q] = replay_on && rep1_d[q].valid && (slot == SLOT_W'(rep1_d[q].slot_time));
            hit2[q] = replay_on && rep2_d[q].valid && (slot == SLOT_W'(rep2_d[q].slot_time));
        end
`ifdef SPIKE_DEMUX_HOLD_EN
        out1_d = hit1 | (out1_q & ~{Q{io.gamma_start}});
        out2_d = hit2 | (out2_q & ~{Q{io.gamma_start}});
`else
        out1_d = hit1;
        out2_d = hit2;
`endif
        early_start_d = io.gamma_start && (slot_q < SLOT_LAST) && (state_q != IDLE);
    end

    spike_capture_bank #(.Q(Q)) u_bank1 (
        .clk      (clk),
        .rstb     (rstb),
        .clear_i  (io.gamma_start),
        .en_i     (capture_on && in_half1),
        .spikes_i (io.col_spikes),
        .time_i   (time1),
        .bank_o   (cap1)
    );

    spike_capture_bank #(.Q(Q)) u_bank2 (
        .clk      (clk),
        .rstb     (rstb),
        .clear_i  (io.gamma_start),
        .en_i     (capture_on && !in_half1),
        .spikes_i (io.col_spikes),
        .time_i   (time2),
        .bank_o   (cap2)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= IDLE;
            slot_q         <= '0;
            rep1_q         <= '0;
            rep2_q         <= '0;
            out1_q         <= '0;
            out2_q         <= '0;
            replay_valid_q <= 1'b0;
            early_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            rep1_q         <= rep1_d;
            rep2_q         <= rep2_d;
            out1_q         <= out1_d;
            out2_q         <= out2_d;
            replay_valid_q <= replay_on;
            early_start_q  <= early_start_d;
        end
    end

    assign io.output_spikes1 = out1_q;
    assign io.output_spikes2 = out2_q;
    assign io.replay_valid   = replay_valid_q;
    assign io.early_start    = early_start_q;

endmodule

// File: tb/tb_spike_output_demux.sv
// Scoreboard bench: captures predicted at drive time become replay expectations at the following gamma_start.
module tb_spike_output_demux;
    import spike_demux_pkg::*;

    localparam int Q    = 2;
    localparam int HL   = 18;
    localparam int WIN  = 2 * HL;
    localparam int LAST = WIN - 1;

    typedef struct {
        int           cyc;
        logic [Q-1:0] o1;
        logic [Q-1:0] o2;
    } exp_t;

    logic clk = 1'b0;
    logic rstb;

    spike_output_demux_if #(.Q(Q)) io ();

    spike_output_demux #(.Q(Q), .HALF_LEN(HL)) dut (
        .clk  (clk),
        .rstb (rstb),
        .io   (io)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t pending[$];
    int   cyc = 0;
    int   gcount = 0;
    int   cnt_q = 0;
    bit   cap_v[2][Q];
    int   cap_t[2][Q];
    int   pulse1, pulse2, early_cnt;

    task automatic clear_caps();
        for (int h = 0; h < 2; h++)
            for (int q = 0; q < Q; q++) cap_v[h][q] = 1'b0;
    endtask

    // One clock of stimulus; the spec-level model predicts and the outputs are compared after the edge.
    task automatic drive_cycle(input logic gs, input logic [Q-1:0] spk);
        int           slot, half;
        logic         exp_early;
        logic [Q-1:0] e1, e2;
        exp_t         e;
        exp_early = 1'b0;
        if (gs) begin
            slot = 0;
            if (gcount >= 1) begin
                exp_early = (cnt_q < LAST);
                for (int i = pending.size() - 1; i >= 0; i--)
                    if (pending[i].cyc >= cyc) pending.delete(i);
                for (int h = 0; h < 2; h++)
                    for (int q = 0; q < Q; q++)
                        if (cap_v[h][q]) begin
                            e.cyc = cyc + cap_t[h][q];
                            e.o1  = '0;
                            e.o2  = '0;
                            if (h == 0) e.o1[q] = 1'b1;
                            else        e.o2[q] = 1'b1;
                            pending.push_back(e);
                        end
            end
            gcount++;
            clear_caps();
        end else begin
            slot = cnt_q;
        end
        if (gcount >= 1) begin
            half = (slot < HL) ? 0 : 1;
            for (int q = 0; q < Q; q++)
                if (spk[q] && !cap_v[half][q]) begin
                    cap_v[half][q] = 1'b1;
                    cap_t[half][q] = slot - half * HL;
                end
        end
        io.gamma_start = gs;
        io.col_spikes  = spk;
        @(posedge clk);
        #1;
        e1 = '0;
        e2 = '0;
        for (int i = pending.size() - 1; i >= 0; i--)
            if (pending[i].cyc == cyc) begin
                e1 |= pending[i].o1;
                e2 |= pending[i].o2;
                pending.delete(i);
            end
        checks++;
        if (io.output_spikes1 !== e1) begin
            errors++;
            $display("FAIL out1 cyc=%0d got=%b want=%b", cyc, io.output_spikes1, e1);
        end
        checks++;
        if (io.output_spikes2 !== e2) begin
            errors++;
            $display("FAIL out2 cyc=%0d got=%b want=%b", cyc, io.output_spikes2, e2);
        end
        checks++;
        if (io.replay_valid !== (gcount >= 2)) begin
            errors++;
            $display("FAIL replay_valid cyc=%0d got=%b want=%b", cyc, io.replay_valid, gcount >= 2);
        end
        checks++;
        if (io.early_start !== exp_early) begin
            errors++;
            $display("FAIL early_start cyc=%0d got=%b want=%b", cyc, io.early_start, exp_early);
        end
        pulse1    += $countones(io.output_spikes1);
        pulse2    += $countones(io.output_spikes2);
        early_cnt += int'(io.early_start);
        cnt_q = (slot < LAST) ? slot + 1 : LAST;
        cyc++;
    endtask

    // Window of len cycles opened by gamma_start, with up to three spike events (slot -1 = unused).
    task automatic run_window(input int len,
                              input int s0, input logic [Q-1:0] v0,
                              input int s1, input logic [Q-1:0] v1,
                              input int s2, input logic [Q-1:0] v2);
        logic [Q-1:0] spk;
        for (int s = 0; s < len; s++) begin
            spk = '0;
            if (s == s0) spk |= v0;
            if (s == s1) spk |= v1;
            if (s == s2) spk |= v2;
            drive_cycle(s == 0, spk);
        end
    endtask

    task automatic zero_counts();
        pulse1    = 0;
        pulse2    = 0;
        early_cnt = 0;
    endtask

    task automatic check_counts(input string name, input int w1, input int w2, input int we);
        checks++;
        if (pulse1 !== w1 || pulse2 !== w2 || early_cnt !== we) begin
            errors++;
            $display("FAIL %s pulses1=%0d pulses2=%0d early=%0d want %0d/%0d/%0d",
                     name, pulse1, pulse2, early_cnt, w1, w2, we);
        end
    endtask

    task automatic apply_reset();
        io.gamma_start = 1'b0;
        io.col_spikes  = '0;
        rstb = 1'b0;
        #1;
        checks++;
        if ({io.output_spikes1, io.output_spikes2, io.replay_valid, io.early_start} !== '0) begin
            errors++;
            $display("FAIL async_reset got o1=%b o2=%b rv=%b es=%b want all 0",
                     io.output_spikes1, io.output_spikes2, io.replay_valid, io.early_start);
        end
        pending.delete();
        gcount = 0;
        cnt_q  = 0;
        clear_caps();
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        // IDLE must ignore column spikes entirely.
        repeat (3) drive_cycle(1'b0, 2'b11);
    endtask

    task automatic test_basic();
        run_window(WIN, 3, 2'b01, 22, 2'b10, -1, '0);
        check_counts("capture_only_silent", 0, 0, 0);
        zero_counts();
        run_window(WIN, -1, '0, -1, '0, -1, '0);
        check_counts("basic_replay", 1, 1, 0);
    endtask

    task automatic test_first_spike();
        zero_counts();
        run_window(WIN, 2, 2'b01, 5, 2'b01, 7, 2'b01);
        check_counts("after_silent_window", 0, 0, 0);
        zero_counts();
        run_window(WIN, -1, '0, -1, '0, -1, '0);
        check_counts("first_spike_only", 1, 0, 0);
    endtask

    task automatic test_silent();
        zero_counts();
        run_window(WIN, -1, '0, -1, '0, -1, '0);
        check_counts("silent_window", 0, 0, 0);
        checks++;
        if (io.replay_valid !== 1'b1) begin
            errors++;
            $display("FAIL silent_replay_valid got=%b want=1", io.replay_valid);
        end
    endtask

    task automatic test_early();
        run_window(20, 6, 2'b01, 19, 2'b10, -1, '0);
        zero_counts();
        run_window(WIN, -1, '0, -1, '0, -1, '0);
        check_counts("early_start", 1, 1, 1);
    endtask

    task automatic test_saturate();
        run_window(40, 36, 2'b10, 38, 2'b10, 39, 2'b01);
        zero_counts();
        run_window(WIN, -1, '0, -1, '0, -1, '0);
        check_counts("saturated_slot", 0, 2, 0);
    endtask

    task automatic test_mid_reset();
        run_window(WIN, 4, 2'b01, -1, '0, -1, '0);
        zero_counts();
        run_window(10, -1, '0, -1, '0, -1, '0);
        check_counts("replay_before_reset", 1, 0, 0);
        apply_reset();
        zero_counts();
        run_window(WIN, 3, 2'b01, 20, 2'b10, -1, '0);
        check_counts("restart_capture_only", 0, 0, 0);
        zero_counts();
        run_window(WIN, -1, '0, -1, '0, -1, '0);
        check_counts("restart_replay", 1, 1, 0);
    endtask

    initial begin
        rstb           = 1'b1;
        io.gamma_start = 1'b0;
        io.col_spikes  = '0;
        #2;
        test_reset();
        test_basic();
        test_first_spike();
        test_silent();
        test_early();
        test_saturate();
        test_mid_reset();
        checks++;
        if (pending.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want 0", pending.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
